// File: rtl/if_stage.sv
// Instruction fetch stage: issues credit-limited fetches to instruction memory,
// buffers in-order responses for decode, and squashes stale fetches on a jump.
module if_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            jump,
    output logic            pause,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            id_valid,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    logic [CW-1:0] inFlight_q, inFlight_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] dropCnt_q, dropCnt_d;
    logic [PW-1:0] aqWr_q, aqWr_d, aqRd_q, aqRd_d;
    logic [PW-1:0] bufWr_q, bufWr_d, bufRd_q, bufRd_d;

    logic [XLEN-1:0] aqMem [DEPTH];
    logic [XLEN-1:0] bufPc [DEPTH];
    logic [31:0]     bufInst [DEPTH];

    logic [CW:0] creditUsed;
    logic        fire;
    logic        respAccept;
    logic        respKeep;
    logic        idPop;

    // Every outstanding fetch owns a buffer slot, so a kept response can never overflow.
    assign creditUsed     = {1'b0, inFlight_q} + {1'b0, count_q};
    assign imem_req_valid = !jump && (creditUsed < {1'b0, DEPTH_C});
    assign imem_req_addr  = pc_in;
    assign fire           = imem_req_valid && imem_req_ready;
    assign pause          = !jump && !fire;

    assign respAccept = imem_resp_valid && (inFlight_q != '0);
    assign respKeep   = respAccept && (dropCnt_q == '0) && !jump;

    assign id_valid = (count_q != '0) && !jump;
    assign id_inst  = bufInst[bufRd_q];
    assign id_pc    = bufPc[bufRd_q];
    assign idPop    = id_valid && id_ready;

    always_comb begin
        inFlight_d = inFlight_q;
        dropCnt_d  = dropCnt_q;
        count_d    = count_q;
        aqWr_d     = aqWr_q;
        aqRd_d     = aqRd_q;
        bufWr_d    = bufWr_q;
        bufRd_d    = bufRd_q;

        if (fire && !respAccept) begin
            inFlight_d = inFlight_q + ONE_C;
        end else if (!fire && respAccept) begin
            inFlight_d = inFlight_q - ONE_C;
        end

        if (fire) begin
            aqWr_d = aqWr_q + PONE_C;
        end
        if (respAccept) begin
            aqRd_d = aqRd_q + PONE_C;
        end

        // A jump marks every fetch still outstanding after this cycle as stale.
        if (jump) begin
            dropCnt_d = respAccept ? (inFlight_q - ONE_C) : inFlight_q;
            count_d   = '0;
            bufWr_d   = '0;
            bufRd_d   = '0;
        end else begin
            if (respAccept && (dropCnt_q != '0)) begin
                dropCnt_d = dropCnt_q - ONE_C;
            end
            if (respKeep && !idPop) begin
                count_d = count_q + ONE_C;
            end else if (!respKeep && idPop) begin
                count_d = count_q - ONE_C;
            end
            if (respKeep) begin
                bufWr_d = bufWr_q + PONE_C;
            end
            if (idPop) begin
                bufRd_d = bufRd_q + PONE_C;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inFlight_q <= '0;
            dropCnt_q  <= '0;
            count_q    <= '0;
            aqWr_q     <= '0;
            aqRd_q     <= '0;
            bufWr_q    <= '0;
            bufRd_q    <= '0;
        end else begin
            inFlight_q <= inFlight_d;
            dropCnt_q  <= dropCnt_d;
            count_q    <= count_d;
            aqWr_q     <= aqWr_d;
            aqRd_q     <= aqRd_d;
            bufWr_q    <= bufWr_d;
            bufRd_q    <= bufRd_d;
        end
    end

    // Storage arrays need no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (fire) begin
            aqMem[aqWr_q] <= pc_in;
        end
        if (respKeep) begin
            bufInst[bufWr_q] <= imem_resp_data;
            bufPc[bufWr_q]   <= aqMem[aqRd_q];
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a queue-based memory and fetch model with jump
// epochs predicts every output each cycle, plus directed literal scenarios.
module tb_if_stage;

    // Four entries let the credit loop sustain one instruction per cycle.
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        jump;
    logic        pause;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;

    if_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .pc_in(pc_in),
        .jump(jump),
        .pause(pause),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .id_valid(id_valid),
        .id_inst(id_inst),
        .id_pc(id_pc),
        .id_ready(id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        int          epoch;
    } memReq_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } bufEntry_t;

    memReq_t     pending[$];
    bufEntry_t   buffer[$];
    int          epoch;
    int          cycle;
    logic [31:0] pcModel;

    int vectors;
    int miscompares;

    logic        obsIdValid;
    logic [31:0] obsIdPc;
    logic        obsPause;
    logic        obsReqValid;
    logic [31:0] obsReqAddr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT to the model, advance the model across the edge.
    task automatic applyStimulus(input logic jmp, input logic [31:0] tgt, input logic rdy,
                                 input logic idr, input int lat, input logic garbage);
        logic    respNow;
        logic    expReqValid;
        logic    expFire;
        logic    expPause;
        logic    expIdValid;
        memReq_t r;
        @(negedge clk);
        respNow         = (pending.size() != 0) && (pending[0].due <= cycle);
        jump            = jmp;
        imem_req_ready  = rdy;
        id_ready        = idr;
        imem_resp_valid = respNow || (garbage && pending.size() == 0);
        imem_resp_data  = respNow ? pending[0].data : $urandom();
        pc_in           = pcModel;
        #1;
        expReqValid = !jmp && ((pending.size() + buffer.size()) < DEPTH);
        expFire     = expReqValid && rdy;
        expPause    = !jmp && !expFire;
        expIdValid  = !jmp && (buffer.size() != 0);
        checkOutput("req_valid", 32'(imem_req_valid), 32'(expReqValid));
        checkOutput("req_addr", imem_req_addr, pcModel);
        checkOutput("pause", 32'(pause), 32'(expPause));
        checkOutput("id_valid", 32'(id_valid), 32'(expIdValid));
        if (expIdValid) begin
            checkOutput("id_pc", id_pc, buffer[0].addr);
            checkOutput("id_inst", id_inst, buffer[0].data);
        end
        obsIdValid  = id_valid;
        obsIdPc     = id_pc;
        obsPause    = pause;
        obsReqValid = imem_req_valid;
        obsReqAddr  = imem_req_addr;

        if (jmp) begin
            if (respNow) begin
                void'(pending.pop_front());
            end
            buffer.delete();
            epoch++;
            pcModel = tgt;
        end else begin
            if (expIdValid && idr) begin
                void'(buffer.pop_front());
            end
            if (respNow) begin
                r = pending.pop_front();
                if (r.epoch == epoch) begin
                    buffer.push_back('{addr: r.addr, data: r.data});
                end
            end
            if (expFire) begin
                pending.push_back('{addr: pcModel, data: $urandom(), due: cycle + lat, epoch: epoch});
                pcModel = pcModel + 32'd4;
            end
        end
        cycle++;
    endtask

    task automatic doReset(input logic [31:0] startPc);
        @(negedge clk);
        rst             = 1'b1;
        jump            = 1'b0;
        imem_resp_valid = 1'b0;
        id_ready        = 1'b0;
        imem_req_ready  = 1'b0;
        pc_in           = startPc;
        #1;
        checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("rst_pause_notready", 32'(pause), 32'd1);
        imem_req_ready = 1'b1;
        #1;
        checkOutput("rst_pause_ready", 32'(pause), 32'd0);
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst            = 1'b0;
        pending.delete();
        buffer.delete();
        pcModel = startPc;
    endtask

    task automatic runUntilPresented(input string name, input logic [31:0] expPc);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1, 1'b0);
            if (obsIdValid) begin
                found = 1'b1;
                checkOutput(name, obsIdPc, expPc);
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: no instruction presented within 20 cycles, expected pc %h", name, expPc);
        end
    endtask

    initial begin
        logic [31:0] seenPc [6];
        logic [31:0] startAddr;
        vectors         = 0;
        miscompares     = 0;
        epoch           = 0;
        cycle           = 0;
        pcModel         = 32'd0;
        rst             = 1'b1;
        jump            = 1'b0;
        pc_in           = 32'd0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        id_ready        = 1'b0;

        // Zero-wait memory streams 0x0, 0x4, 0x8 after a two-cycle fill.
        doReset(32'h0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1, 1'b0);
            seenPc[k] = obsIdValid ? obsIdPc : 32'hDEAD_BEEF;
            if (k >= 2) begin
                checkOutput("stream_pause", 32'(obsPause), 32'd0);
            end
        end
        checkOutput("stream_c0", seenPc[0], 32'hDEAD_BEEF);
        checkOutput("stream_c2", seenPc[2], 32'h0);
        checkOutput("stream_c3", seenPc[3], 32'h4);
        checkOutput("stream_c4", seenPc[4], 32'h8);

        // Jump with two fetches outstanding.
        doReset(32'h10);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 3, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 3, 1'b0);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 1, 1'b0);
        checkOutput("jump_pause", 32'(obsPause), 32'd0);
        checkOutput("jump_req_valid", 32'(obsReqValid), 32'd0);
        runUntilPresented("jump_first_pc", 32'h100);

        // Jump coincident with the response for 0x10.
        doReset(32'h10);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2, 1'b0);
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b1, 1, 1'b0);
        checkOutput("jumpresp_id_valid", 32'(obsIdValid), 32'd0);
        runUntilPresented("jumpresp_first_pc", 32'h300);

        // Memory not ready for three cycles.
        doReset(32'h400);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1, 1'b0);
            checkOutput("notready_pause", 32'(obsPause), 32'd1);
            checkOutput("notready_addr", obsReqAddr, 32'h400);
            checkOutput("notready_id_valid", 32'(obsIdValid), 32'd0);
        end
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1, 1'b0);
        checkOutput("ready_again_pause", 32'(obsPause), 32'd0);

        // Decode stalled: the credit limit freezes the PC, then one pop frees one fetch.
        doReset(32'h200);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1, 1'b0);
        end
        checkOutput("stall_req_valid", 32'(obsReqValid), 32'd0);
        checkOutput("stall_pause", 32'(obsPause), 32'd1);
        checkOutput("stall_head_pc", obsIdPc, 32'h200);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1, 1'b0);
        checkOutput("credit_refire", 32'(obsReqValid), 32'd1);
        checkOutput("credit_refire_addr", obsReqAddr, 32'h210);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1, 1'b0);
        checkOutput("credit_exhausted", 32'(obsReqValid), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1, 1'b0);
        checkOutput("full_id_valid", 32'(obsIdValid), 32'd1);

        // Asynchronous reset with a full buffer drops id_valid before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_id_valid", 32'(id_valid), 32'd0);
        doReset(32'h0);

        // Randomized traffic with occasional jumps, stalls and stray responses.
        for (int blk = 0; blk < 4; blk++) begin
            startAddr = {$urandom_range(0, 16'hFFFF), 2'b00};
            doReset(startAddr);
            for (int k = 0; k < 600; k++) begin
                applyStimulus($urandom_range(0, 11) == 0,
                              {$urandom_range(0, 16'hFFFF), 2'b00},
                              $urandom_range(0, 3) != 0,
                              $urandom_range(0, 3) != 0,
                              int'($urandom_range(1, 3)),
                              $urandom_range(0, 15) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath/address width.
REQ-002 Parameter DEPTH, default 2, power of two ≥2; inst buffer entries = max outstanding fetches.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_in  input  XLEN  current program counter value.
REQ-006 jump  input  1  redirect/flush from execute; PC loads new target next edge.
REQ-007 pause  output  1  hold request to PC register.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_addr  output  XLEN  fetch address.
REQ-010 imem_req_ready  input  1  memory accepts request.
REQ-011 imem_resp_valid  input  1  in-order response, no backpressure, ≥1 cycle after acceptance.
REQ-012 imem_resp_data  input  32  fetched instruction word.
REQ-013 id_valid  output  1  instruction available to decode.
REQ-014 id_inst  output  32  instruction to decode.
REQ-015 id_pc  output  XLEN  address of id_inst.
REQ-016 id_ready  input  1  decode consumes entry.

Function
REQ-017 Counters: in_flight (accepted, response not yet received), count (buffer occupancy), drop (responses still to discard); all widths hold 0..DEPTH.
REQ-018 imem_req_valid = !jump && (in_flight + count < DEPTH); imem_req_addr = pc_in, combinational.
REQ-019 Request fires when imem_req_valid && imem_req_ready; fired address pushed into an internal DEPTH-entry address queue.
REQ-020 pause = !jump && !fire; PC advances exactly once per fired request; pause never asserted in a jump cycle.
REQ-021 Response with drop == 0: pop address queue, push {address, resp_data} into inst buffer at edge; id_valid earliest the following cycle (no bypass).
REQ-022 Response with drop > 0: pop address queue, discard data, drop decrements.
REQ-023 id_valid = (count != 0) && !jump; id_inst/id_pc = head entry; pop on id_valid && id_ready.
REQ-024 Simultaneous push and pop: count unchanged, ordering preserved; push when full is impossible by REQ-018 credit rule.
REQ-025 in_flight: +1 on fire, -1 on any response (kept or dropped), both same cycle -> unchanged.
REQ-026 Jump cycle: no request, no id pop; buffer cleared (count=0, pointers reset); same-cycle response discarded; drop <= in_flight after this cycle's response accounting.
REQ-027 Jump while drop > 0: drop recomputed per REQ-026 (superset; no stale response ever reaches decode).
REQ-028 Response while in_flight == 0: protocol error, ignored (no state change).
REQ-029 Pointers wrap modulo DEPTH.

Reset
REQ-030 On rst: in_flight=0, count=0, drop=0, all pointers 0; id_valid=0; imem_req_valid follows REQ-018 (1 when jump=0); pause=!imem_req_ready.
REQ-031 Reset mid-operation abandons all in-flight fetches; memory responses for them must not arrive after rst deasserts (system requirement).

Verification
REQ-032 Zero-wait memory (ready=1, resp next cycle), id_ready=1, pc from 0x0: id_pc sequence 0x0,0x4,0x8 on consecutive cycles after 2-cycle fill; pause=0 steady state.
REQ-033 id_ready=0, DEPTH=2: after 2 fires, imem_req_valid=0, pause=1, PC frozen; id_ready=1 one cycle -> one new fire.
REQ-034 2 requests in flight (0x10,0x14), jump with target 0x100: both responses discarded, next id_pc=0x100, pause=0 in jump cycle.
REQ-035 Jump coincident with response for 0x10 and id_ready=1: id_valid=0 that cycle, 0x10 never presented, drop=in_flight-1.
REQ-036 imem_req_ready held 0 for 3 cycles: pause=1 for 3 cycles, pc_in unchanged, no fire, no id_valid change.
REQ-037 rst asserted with count=2, in_flight=0: id_valid drops immediately (async), counters 0 on release.
